// File: rtl/preamble_inserter_if.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | preamble_inserter_if                                                       |
// | Frame-request / payload-input / framed-I/Q-output bundle of the framer.    |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
interface preamble_inserter_if;
  logic        start;
  logic [15:0] frame_len;
  logic [17:0] data_i;
  logic [17:0] data_q;
  logic        ivalid;
  logic        iready;
  logic [17:0] odata_i;
  logic [17:0] odata_q;
  logic        ovalid;
  logic        osop;
  logic        oeop;
  logic        busy;
  logic        underflow;

  modport master (
    output start, frame_len, data_i, data_q, ivalid,
    input  iready, odata_i, odata_q, ovalid, osop, oeop, busy, underflow
  );

  modport slave (
    input  start, frame_len, data_i, data_q, ivalid,
    output iready, odata_i, odata_q, ovalid, osop, oeop, busy, underflow
  );
endinterface
`default_nettype wire

// File: rtl/preamble_inserter.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | preamble_inserter                                                          |
// | Tx framer: BPSK PN preamble (LFSR x^7+x^6+1) then fixed-timing payload.    |
// | Optional guard zeros after EOP when TX_GUARD_EN is defined.                |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
module preamble_inserter #(
  parameter int          PRE_LEN   = 64,
  parameter logic [6:0]  LFSR_SEED = 7'h5A,
  parameter logic [17:0] AMP       = 18'd8192,
  parameter int          GUARD_LEN = 16
) (
  input  wire logic          clk,
  input  wire logic          rst,
  preamble_inserter_if.slave bus_io
);

  localparam int          c_PRE_W   = $clog2(PRE_LEN + 1);
  localparam logic [17:0] c_NEG_AMP = 18'd0 - AMP;

  if (PRE_LEN < 2 || GUARD_LEN < 1) begin : g_param_check
    $error("preamble_inserter: PRE_LEN must be >= 2 and GUARD_LEN >= 1");
  end

`ifdef TX_GUARD_EN
  localparam int c_GUARD_W = $clog2(GUARD_LEN + 1);
  typedef enum logic [2:0] {S_IDLE, S_PRE, S_PAY, S_GUARD, S_END} state_t;
`else
  typedef enum logic [1:0] {S_IDLE, S_PRE, S_PAY, S_END} state_t;
`endif

  state_t             state_q;
  logic [6:0]         lfsr_q;
  logic [6:0]         lfsr_d;
  logic [c_PRE_W-1:0] pre_cnt_q;
  logic [15:0]        pay_cnt_q;
  logic [17:0]        odata_i_q;
  logic [17:0]        odata_q_q;
  logic               ovalid_q;
  logic               osop_q;
  logic               oeop_q;
  logic               underflow_q;
`ifdef TX_GUARD_EN
  logic [c_GUARD_W-1:0] guard_cnt_q;
`endif

  function automatic logic [6:0] lfsr_step(input logic [6:0] s);
    return {s[5:0], s[6] ^ s[5]};
  endfunction

  function automatic logic [17:0] bpsk(input logic b);
    return b ? AMP : c_NEG_AMP;
  endfunction

  assign lfsr_d = lfsr_step(lfsr_q);

  // The state register leads the output registers by one cycle; S_END keeps
  // busy high while the final sample sits on the outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      lfsr_q      <= LFSR_SEED;
      pre_cnt_q   <= '0;
      pay_cnt_q   <= '0;
      odata_i_q   <= '0;
      odata_q_q   <= '0;
      ovalid_q    <= 1'b0;
      osop_q      <= 1'b0;
      oeop_q      <= 1'b0;
      underflow_q <= 1'b0;
`ifdef TX_GUARD_EN
      guard_cnt_q <= '0;
`endif
    end else begin
      osop_q <= 1'b0;
      oeop_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          ovalid_q  <= 1'b0;
          odata_i_q <= '0;
          odata_q_q <= '0;
          if (bus_io.start) begin
            state_q     <= S_PRE;
            pay_cnt_q   <= bus_io.frame_len;
            underflow_q <= 1'b0;
            odata_i_q   <= bpsk(LFSR_SEED[6]);
            odata_q_q   <= bpsk(LFSR_SEED[6]);
            ovalid_q    <= 1'b1;
            osop_q      <= 1'b1;
            lfsr_q      <= lfsr_step(LFSR_SEED);
            pre_cnt_q   <= c_PRE_W'(1);
          end
        end
        S_PRE: begin
          odata_i_q <= bpsk(lfsr_q[6]);
          odata_q_q <= bpsk(lfsr_q[6]);
          ovalid_q  <= 1'b1;
          lfsr_q    <= lfsr_d;
          pre_cnt_q <= pre_cnt_q + c_PRE_W'(1);
          if (pre_cnt_q == c_PRE_W'(PRE_LEN - 1)) begin
            if (pay_cnt_q != 16'd0) begin
              state_q <= S_PAY;
            end else begin
              oeop_q <= 1'b1;
`ifdef TX_GUARD_EN
              state_q     <= S_GUARD;
              guard_cnt_q <= '0;
`else
              state_q <= S_END;
`endif
            end
          end
        end
        S_PAY: begin
          ovalid_q <= 1'b1;
          if (bus_io.ivalid) begin
            odata_i_q <= bus_io.data_i;
            odata_q_q <= bus_io.data_q;
          end else begin
            odata_i_q   <= '0;
            odata_q_q   <= '0;
            underflow_q <= 1'b1;
          end
          pay_cnt_q <= pay_cnt_q - 16'd1;
          if (pay_cnt_q == 16'd1) begin
            oeop_q <= 1'b1;
`ifdef TX_GUARD_EN
            state_q     <= S_GUARD;
            guard_cnt_q <= '0;
`else
            state_q <= S_END;
`endif
          end
        end
`ifdef TX_GUARD_EN
        S_GUARD: begin
          odata_i_q   <= '0;
          odata_q_q   <= '0;
          ovalid_q    <= 1'b1;
          guard_cnt_q <= guard_cnt_q + c_GUARD_W'(1);
          if (guard_cnt_q == c_GUARD_W'(GUARD_LEN - 1)) begin
            state_q <= S_END;
          end
        end
`endif
        S_END: begin
          ovalid_q  <= 1'b0;
          odata_i_q <= '0;
          odata_q_q <= '0;
          state_q   <= S_IDLE;
        end
        default: begin
          state_q <= S_IDLE;
        end
      endcase
    end
  end

  assign bus_io.iready    = (state_q == S_PAY);
  assign bus_io.busy      = (state_q != S_IDLE);
  assign bus_io.odata_i   = odata_i_q;
  assign bus_io.odata_q   = odata_q_q;
  assign bus_io.ovalid    = ovalid_q;
  assign bus_io.osop      = osop_q;
  assign bus_io.oeop      = oeop_q;
  assign bus_io.underflow = underflow_q;

endmodule
`default_nettype wire
